// File: rtl/ecap5_dproc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecap5_dproc_pkg
// Purpose  : Shared types and constants for the data-processor pipeline.
//            Holds the load-store stage state encoding and the access size
//            masks used by the execute stage to describe memory accesses.
// Revision : 1.0 - initial release
// ============================================================================
package ecap5_dproc_pkg;

    // Load-store stage state encoding
    typedef logic [1:0] lsm_state_t;

    localparam lsm_state_t LSM_IDLE     = 2'd0;
    localparam lsm_state_t LSM_REQUEST  = 2'd1;
    localparam lsm_state_t LSM_WAIT_ACK = 2'd2;
    localparam lsm_state_t LSM_DONE     = 2'd3;

    // Access size masks, LSB-justified before lane alignment
    localparam logic [3:0] LS_SEL_BYTE = 4'b0001;
    localparam logic [3:0] LS_SEL_HALF = 4'b0011;
    localparam logic [3:0] LS_SEL_WORD = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/lsm_align.sv
`default_nettype none
// ============================================================================
// Module   : lsm_align
// Purpose  : Combinational byte-lane alignment for the load-store stage.
//            Store side: shifts the LSB-justified size mask and store data up
//            to the byte lane selected by the address offset.
//            Load side : shifts the read word down by the address offset and
//            sign- or zero-extends the selected byte/half field.
// Ports    :
//   st_off_i      in  2   store address offset (addr[1:0])
//   st_sel_i      in  4   store/load size mask, LSB-justified
//   st_data_i     in  32  store data, LSB-justified
//   st_sel_o      out 4   lane select, truncated to the addressed word
//   st_data_o     out 32  lane-shifted store data
//   ld_off_i      in  2   load address offset
//   ld_sel_i      in  4   load size mask, LSB-justified
//   ld_unsigned_i in  1   zero-extend instead of sign-extend
//   ld_data_i     in  32  raw bus read word
//   ld_data_o     out 32  aligned and extended load result
// Revision : 1.0 - initial release
// ============================================================================
module lsm_align
    import ecap5_dproc_pkg::*;
(
    input  logic [1:0]  st_off_i,
    input  logic [3:0]  st_sel_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_sel_o,
    output logic [31:0] st_data_o,
    input  logic [1:0]  ld_off_i,
    input  logic [3:0]  ld_sel_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_data_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] w_ld_shifted;
    logic        w_ld_ext;

    // Lanes pushed past byte 3 by a misaligned access are dropped: the
    // access is truncated to the addressed word.
    always_comb begin
        st_sel_o = st_sel_i;
        case (st_off_i)
            2'd0:    st_sel_o = st_sel_i;
            2'd1:    st_sel_o = {st_sel_i[2:0], 1'b0};
            2'd2:    st_sel_o = {st_sel_i[1:0], 2'b00};
            default: st_sel_o = {st_sel_i[0], 3'b000};
        endcase
    end

    assign st_data_o = st_data_i << {st_off_i, 3'b000};

    always_comb begin
        w_ld_shifted = ld_data_i >> {ld_off_i, 3'b000};
        w_ld_ext     = 1'b0;
        ld_data_o    = w_ld_shifted;
        if (ld_sel_i == LS_SEL_BYTE) begin
            w_ld_ext  = ~ld_unsigned_i & w_ld_shifted[7];
            ld_data_o = {{24{w_ld_ext}}, w_ld_shifted[7:0]};
        end else if (ld_sel_i == LS_SEL_HALF) begin
            w_ld_ext  = ~ld_unsigned_i & w_ld_shifted[15];
            ld_data_o = {{16{w_ld_ext}}, w_ld_shifted[15:0]};
        end
        // Any other mask is treated as a full word: no extension needed.
    end

endmodule
`default_nettype wire

// File: rtl/lsm.sv
`default_nettype none
// ============================================================================
// Module   : lsm
// Purpose  : Load-store memory stage between execute and write-back.
//            Non-memory instructions pass straight through in one cycle.
//            Loads and stores run a single Wishbone B4 pipelined master
//            transaction and present the (aligned, extended) result to
//            write-back as a one-cycle output_valid_o pulse.
// Ports    :
//   clk_i, rst_i                     clock, async active-high reset
//   input_valid_i / input_ready_o    upstream handshake (ready only in IDLE)
//   result_i                         execute result / byte address
//   ls_enable_i, ls_write_i          memory access, store select
//   ls_write_data_i, ls_sel_i        store data, access size mask
//   ls_unsigned_load_i               zero-extend loads
//   reg_write_i, reg_addr_i          write-back controls pass-through
//   wb_adr_o .. wb_cyc_o             Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_stall_i   Wishbone master inputs
//   output_valid_o                   write-back entry valid pulse
//   reg_write_o, reg_addr_o,
//   reg_data_o                       write-back entry
// Revision : 1.0 - initial release
// ============================================================================
module lsm
    import ecap5_dproc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        input_valid_i,
    output logic        input_ready_o,

    input  logic [31:0] result_i,
    input  logic        ls_enable_i,
    input  logic        ls_write_i,
    input  logic [31:0] ls_write_data_i,
    input  logic [3:0]  ls_sel_i,
    input  logic        ls_unsigned_load_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,

    output logic        output_valid_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_data_o
);

    // ------------------------------------------------------------------------
    // State and captured instruction fields
    // ------------------------------------------------------------------------
    lsm_state_t  state_q,         state_d;
    logic [1:0]  off_q,           off_d;
    logic [3:0]  sel_q,           sel_d;
    logic        unsigned_q,      unsigned_d;
    logic        cap_reg_write_q, cap_reg_write_d;
    logic [4:0]  cap_reg_addr_q,  cap_reg_addr_d;

    // Registered outputs
    logic [31:0] wb_adr_q,        wb_adr_d;
    logic [31:0] wb_dat_q,        wb_dat_d;
    logic        wb_we_q,         wb_we_d;
    logic [3:0]  wb_sel_q,        wb_sel_d;
    logic        wb_stb_q,        wb_stb_d;
    logic        wb_cyc_q,        wb_cyc_d;
    logic        out_valid_q,     out_valid_d;
    logic        out_reg_write_q, out_reg_write_d;
    logic [4:0]  out_reg_addr_q,  out_reg_addr_d;
    logic [31:0] out_reg_data_q,  out_reg_data_d;

    logic        w_transfer;
    logic        w_complete;
    logic [3:0]  w_st_sel;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_data;

    // ------------------------------------------------------------------------
    // Lane alignment: the store side works on the live inputs (used while
    // IDLE to build the request), the load side on the captured fields.
    // ------------------------------------------------------------------------
    lsm_align u_align (
        .st_off_i      (result_i[1:0]),
        .st_sel_i      (ls_sel_i),
        .st_data_i     (ls_write_data_i),
        .st_sel_o      (w_st_sel),
        .st_data_o     (w_st_data),
        .ld_off_i      (off_q),
        .ld_sel_i      (sel_q),
        .ld_unsigned_i (unsigned_q),
        .ld_data_i     (wb_dat_i),
        .ld_data_o     (w_ld_data)
    );

    assign input_ready_o = (state_q == LSM_IDLE);
    assign w_transfer    = input_valid_i & input_ready_o;

    // An ack only counts once the request has been accepted: either in the
    // accepting REQUEST cycle itself (stall low) or later in WAIT_ACK.
    assign w_complete = ((state_q == LSM_REQUEST) & ~wb_stall_i & wb_ack_i) |
                        ((state_q == LSM_WAIT_ACK) & wb_ack_i);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        off_d           = off_q;
        sel_d           = sel_q;
        unsigned_d      = unsigned_q;
        cap_reg_write_d = cap_reg_write_q;
        cap_reg_addr_d  = cap_reg_addr_q;
        wb_adr_d        = wb_adr_q;
        wb_dat_d        = wb_dat_q;
        wb_we_d         = wb_we_q;
        wb_sel_d        = wb_sel_q;
        wb_stb_d        = wb_stb_q;
        wb_cyc_d        = wb_cyc_q;
        out_valid_d     = 1'b0;
        out_reg_write_d = out_reg_write_q;
        out_reg_addr_d  = out_reg_addr_q;
        out_reg_data_d  = out_reg_data_q;

        case (state_q)
            LSM_IDLE: begin
                if (w_transfer) begin
                    if (ls_enable_i) begin
                        off_d           = result_i[1:0];
                        sel_d           = ls_sel_i;
                        unsigned_d      = ls_unsigned_load_i;
                        cap_reg_write_d = reg_write_i;
                        cap_reg_addr_d  = reg_addr_i;
                        wb_adr_d        = {result_i[31:2], 2'b00};
                        wb_dat_d        = w_st_data;
                        wb_sel_d        = w_st_sel;
                        wb_we_d         = ls_write_i;
                        wb_stb_d        = 1'b1;
                        wb_cyc_d        = 1'b1;
                        state_d         = LSM_REQUEST;
                    end else begin
                        // Pass-through: stay in IDLE for full throughput
                        out_valid_d     = 1'b1;
                        out_reg_write_d = reg_write_i;
                        out_reg_addr_d  = reg_addr_i;
                        out_reg_data_d  = result_i;
                    end
                end
            end

            LSM_REQUEST: begin
                // Address, data and sel stay put while the slave stalls
                if (!wb_stall_i) begin
                    wb_stb_d = 1'b0;
                    state_d  = LSM_WAIT_ACK;
                end
            end

            LSM_WAIT_ACK: begin
                state_d = LSM_WAIT_ACK;
            end

            LSM_DONE: begin
                state_d = LSM_IDLE;
            end

            default: begin
                state_d = LSM_IDLE;
            end
        endcase

        // Completion overrides the REQUEST/WAIT_ACK defaults above
        if (w_complete) begin
            wb_stb_d        = 1'b0;
            wb_cyc_d        = 1'b0;
            state_d         = LSM_DONE;
            out_valid_d     = 1'b1;
            out_reg_write_d = ~wb_we_q & cap_reg_write_q;
            out_reg_addr_d  = cap_reg_addr_q;
            out_reg_data_d  = w_ld_data;
        end
    end

    // ------------------------------------------------------------------------
    // Registers; reset drops the bus cycle immediately
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= LSM_IDLE;
            off_q           <= 2'd0;
            sel_q           <= 4'd0;
            unsigned_q      <= 1'b0;
            cap_reg_write_q <= 1'b0;
            cap_reg_addr_q  <= 5'd0;
            wb_adr_q        <= 32'd0;
            wb_dat_q        <= 32'd0;
            wb_we_q         <= 1'b0;
            wb_sel_q        <= 4'd0;
            wb_stb_q        <= 1'b0;
            wb_cyc_q        <= 1'b0;
            out_valid_q     <= 1'b0;
            out_reg_write_q <= 1'b0;
            out_reg_addr_q  <= 5'd0;
            out_reg_data_q  <= 32'd0;
        end else begin
            state_q         <= state_d;
            off_q           <= off_d;
            sel_q           <= sel_d;
            unsigned_q      <= unsigned_d;
            cap_reg_write_q <= cap_reg_write_d;
            cap_reg_addr_q  <= cap_reg_addr_d;
            wb_adr_q        <= wb_adr_d;
            wb_dat_q        <= wb_dat_d;
            wb_we_q         <= wb_we_d;
            wb_sel_q        <= wb_sel_d;
            wb_stb_q        <= wb_stb_d;
            wb_cyc_q        <= wb_cyc_d;
            out_valid_q     <= out_valid_d;
            out_reg_write_q <= out_reg_write_d;
            out_reg_addr_q  <= out_reg_addr_d;
            out_reg_data_q  <= out_reg_data_d;
        end
    end

    assign wb_adr_o       = wb_adr_q;
    assign wb_dat_o       = wb_dat_q;
    assign wb_we_o        = wb_we_q;
    assign wb_sel_o       = wb_sel_q;
    assign wb_stb_o       = wb_stb_q;
    assign wb_cyc_o       = wb_cyc_q;
    assign output_valid_o = out_valid_q;
    assign reg_write_o    = out_reg_write_q;
    assign reg_addr_o     = out_reg_addr_q;
    assign reg_data_o     = out_reg_data_q;

endmodule
`default_nettype wire

// File: doc/lsm.md
Name: lsm

Overview:
- Load-store memory stage, directly downstream of the execute stage and directly upstream of write-back.
- Consumes the execute-stage result (ALU output, used as address for memory ops) plus load-store and write-back pass-through controls.
- Performs a single Wishbone B4 pipelined master transaction for loads and stores: byte-lane alignment on the way out, alignment and sign/zero extension on the way back.
- Non-memory instructions pass through in one cycle.

Parameters:
- None.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- input_valid_i  in  1  upstream transfer valid
- input_ready_o  out  1  stage can accept a transfer
- result_i  in  32  execute result; byte address when ls_enable_i=1
- ls_enable_i  in  1  instruction is a memory access
- ls_write_i  in  1  1=store, 0=load
- ls_write_data_i  in  32  store data, LSB-justified
- ls_sel_i  in  4  access size mask: 4'b0001 byte, 4'b0011 half, 4'b1111 word
- ls_unsigned_load_i  in  1  zero-extend instead of sign-extend
- reg_write_i  in  1  write-back enable pass-through
- reg_addr_i  in  5  destination register pass-through
- wb_adr_o  out  32  word address {addr[31:2],2'b00}
- wb_dat_o  out  32  lane-shifted store data
- wb_dat_i  in  32  read data
- wb_we_o  out  1  write enable
- wb_sel_o  out  4  lane select
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_ack_i  in  1  acknowledge
- wb_stall_i  in  1  slave stall
- output_valid_o  out  1  write-back entry valid (one-cycle pulse)
- reg_write_o  out  1  write-back enable
- reg_addr_o  out  5  destination register
- reg_data_o  out  32  write-back data

Behaviour:
- Reset (async assert, sync deassert by the system):
  - all outputs 0
  - state IDLE
  - wb_cyc_o/wb_stb_o drop immediately, even mid-transaction; a late ack after reset is ignored.
- FSM states: IDLE, REQUEST, WAIT_ACK, DONE.
- input_ready_o = (state==IDLE). A transfer occurs when input_valid_i && input_ready_o.
- IDLE, transfer with ls_enable_i=0:
  - next cycle: output_valid_o=1, reg_data_o=result_i, reg_write_o=reg_write_i, reg_addr_o=reg_addr_i
  - state stays IDLE, giving one instruction per cycle throughput.
- IDLE, transfer with ls_enable_i=1:
  - capture all inputs; go to REQUEST.
  - Next cycle: wb_cyc_o=1, wb_stb_o=1, wb_we_o=ls_write_i.
  - Lane offset off=addr[1:0]: wb_sel_o=(ls_sel_i<<off)[3:0], wb_dat_o=ls_write_data_i<<(8*off).
- REQUEST:
  - wb_stb_o is held with stable address, data and sel while wb_stall_i=1.
  - On the first cycle with wb_stall_i=0, the request is accepted; next cycle wb_stb_o=0 and state goes to WAIT_ACK (wb_cyc_o stays 1).
  - If wb_ack_i arrives in the same cycle the request is accepted, go directly to DONE.
- WAIT_ACK: hold wb_cyc_o until wb_ack_i; then go to DONE. No timeout.
- On ack, registered in DONE, for one cycle:
  - output_valid_o=1, reg_addr_o=captured address.
  - Store: reg_write_o=0.
  - Load: reg_write_o=captured reg_write_i.
  - Load data: shifted=wb_dat_i>>(8*off); byte -> {24{ext},shifted[7:0]}; half -> {16{ext},shifted[15:0]}; word -> shifted.
  - ext = unsigned ? 0 : sign bit of the selected field.
  - DONE returns to IDLE next cycle; input_ready_o deasserts from acceptance through DONE inclusive.
- output_valid_o is 0 in every cycle not listed above, and reg_* outputs hold their last values.
- Accesses whose shifted sel exceeds 4 bits (word-crossing misalignment) are truncated to the in-word lanes; misalignment trapping is out of scope.
- input_valid_i while input_ready_o=0 is ignored; upstream holds the transfer.
- Loads with reg_addr_i=0 still perform the bus access; the register file discards the write.

Decomposition:
- Package ecap5_dproc_pkg gains:
  - lsm state enum (IDLE, REQUEST, WAIT_ACK, DONE)
  - size masks LS_SEL_BYTE=4'b0001, LS_SEL_HALF=4'b0011, LS_SEL_WORD=4'b1111.
- One sub-module, lsm_align: combinational store-lane shifter and load extract/extend, reused by the bench's reference model.

Test Plan:
- Pass-through: result_i=32'h1234_5678, ls_enable_i=0, reg_write_i=1, reg_addr_i=5 -> next cycle output_valid_o=1, reg_data_o=32'h1234_5678, reg_addr_o=5, no wb_cyc_o.
- Signed byte load: addr=32'h0000_1002, sel=4'b0001, wb_dat_i=32'h00F1_0000, ack after 2 wait cycles -> wb_adr_o=32'h1000, wb_sel_o=4'b0100, reg_data_o=32'hFFFF_FFF1; with ls_unsigned_load_i=1 -> 32'h0000_00F1.
- Half store: addr=32'h0000_2002, data=32'h0000_BEEF, sel=4'b0011 -> wb_we_o=1, wb_sel_o=4'b1100, wb_dat_o=32'hBEEF_0000; on ack output_valid_o=1, reg_write_o=0.
- Stall: wb_stall_i=1 for 3 cycles on a word load -> wb_stb_o held with stable address for 4 cycles total; input_ready_o=0 throughout; single request accepted.
- Ack coincident with stall release -> completes with no WAIT_ACK cycle; back-to-back pass-through accepted the cycle after DONE.
- Async reset mid-WAIT_ACK -> wb_cyc_o=0 and input_ready_o=1 without a clock edge; a following stray ack produces no output_valid_o.
